// File: rtl/ucsbece154a_mem_arbiter_if.sv
// Requester ports and unified memory port of the two-way memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requester and memory side.
interface ucsbece154a_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              core_req_i;
   logic              core_we_i;
   logic [ADDR_W-1:0] core_addr_i;
   logic [DATA_W-1:0] core_wdata_i;
   logic              core_ack_o;
   logic [DATA_W-1:0] core_rdata_o;
   logic              aux_req_i;
   logic              aux_we_i;
   logic [ADDR_W-1:0] aux_addr_i;
   logic [DATA_W-1:0] aux_wdata_i;
   logic              aux_ack_o;
   logic [DATA_W-1:0] aux_rdata_o;
   logic              err_o;
   logic              busy_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ready_i;

   modport slave (
      input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
      input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
      input  mem_rdata_i, mem_ready_i,
      output core_ack_o, core_rdata_o, aux_ack_o, aux_rdata_o, err_o, busy_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output core_req_i, core_we_i, core_addr_i, core_wdata_i,
      output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
      output mem_rdata_i, mem_ready_i,
      input  core_ack_o, core_rdata_o, aux_ack_o, aux_rdata_o, err_o, busy_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/ucsbece154a_mem_arbiter.sv
// Core/aux arbiter for the unified memory port: grant -> held BUSY request -> 1-cycle ack, err_o on MAX_WAIT timeout.
// Ack arrives one cycle after mem_ready_i; requests are ignored outside IDLE; UCSBECE154A_ARB_RR_EN selects round-robin.
module ucsbece154a_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   ucsbece154a_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic {GRANT_CORE = 1'b0, GRANT_AUX = 1'b1} grant_t;
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t            state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              core_ack_q, core_ack_d;
   logic              aux_ack_q, aux_ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
   logic [DATA_W-1:0] resp_dat;
   logic              win_aux;

`ifdef UCSBECE154A_ARB_RR_EN
   assign win_aux = bus.aux_req_i && (!bus.core_req_i || last_grant_q == GRANT_CORE);
`else
   assign win_aux = !bus.core_req_i;
`endif

   // A timeout returns zero data to the owner, so the owner never sees stale data flagged as valid.
   assign resp_dat = bus.mem_ready_i ? bus.mem_rdata_i : '0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      core_ack_d   = 1'b0;
      aux_ack_d    = 1'b0;
      err_d        = 1'b0;
      core_rdata_d = core_rdata_q;
      aux_rdata_d  = aux_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.core_req_i || bus.aux_req_i) begin
               state_d   = BUSY;
               mem_req_d = 1'b1;
               cnt_d     = '0;
               if (win_aux) begin
                  last_grant_d = GRANT_AUX;
                  cmd_d        = {bus.aux_we_i, bus.aux_addr_i, bus.aux_wdata_i};
               end else begin
                  last_grant_d = GRANT_CORE;
                  cmd_d        = {bus.core_we_i, bus.core_addr_i, bus.core_wdata_i};
               end
            end
         end
         BUSY: begin
            if (bus.mem_ready_i || cnt_q == WAIT_LAST) begin
               state_d    = RESP;
               mem_req_d  = 1'b0;
               err_d      = !bus.mem_ready_i;
               core_ack_d = (last_grant_q == GRANT_CORE);
               aux_ack_d  = (last_grant_q == GRANT_AUX);
               if (!bus.mem_ready_i || !cmd_q.we) begin
                  if (last_grant_q == GRANT_AUX) aux_rdata_d  = resp_dat;
                  else                           core_rdata_d = resp_dat;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: state_d = IDLE;
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_AUX;
         cmd_q        <= '0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         core_ack_q   <= 1'b0;
         aux_ack_q    <= 1'b0;
         err_q        <= 1'b0;
         core_rdata_q <= '0;
         aux_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         core_ack_q   <= core_ack_d;
         aux_ack_q    <= aux_ack_d;
         err_q        <= err_d;
         core_rdata_q <= core_rdata_d;
         aux_rdata_q  <= aux_rdata_d;
      end
   end

   assign bus.core_ack_o   = core_ack_q;
   assign bus.core_rdata_o = core_rdata_q;
   assign bus.aux_ack_o    = aux_ack_q;
   assign bus.aux_rdata_o  = aux_rdata_q;
   assign bus.err_o        = err_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.mem_req_o    = mem_req_q;
   assign bus.mem_we_o     = cmd_q.we;
   assign bus.mem_addr_o   = cmd_q.addr;
   assign bus.mem_wdata_o  = cmd_q.wdata;
endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Bench for ucsbece154a_mem_arbiter: directed vector table, hand sequences, then random traffic against a transaction model.
module tb_ucsbece154a_mem_arbiter;
   localparam int MAX_WAIT = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level expectations: who was granted last, what each port's rdata should hold.
   bit          m_last_aux;
   logic [31:0] trk_core_rd, trk_aux_rd;

   typedef struct {
      bit          creq, areq, cwe, awe;
      logic [31:0] caddr, aaddr, cwd, awd;
      int          d;
      logic [31:0] mrd;
      bit          drop_mid;
      bit          exp_aux, exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last_aux  = 1'b1;
      trk_core_rd = '0;
      trk_aux_rd  = '0;
   endtask

   // Called during an IDLE cycle with requests already driven; returns at the negedge of the next IDLE cycle.
   // d = BUSY cycle on which memory answers; d > MAX_WAIT means memory never answers.
   task automatic do_round(input bit exp_aux, input bit exp_err, input logic [31:0] exp_rd,
                           input int d, input logic [31:0] mrd, input bit drop_mid, input bit drop_after);
      logic        we;
      logic [31:0] addr, wd;
      int          nb;
      we   = exp_aux ? bus.aux_we_i    : bus.core_we_i;
      addr = exp_aux ? bus.aux_addr_i  : bus.core_addr_i;
      wd   = exp_aux ? bus.aux_wdata_i : bus.core_wdata_i;
      nb   = (d > MAX_WAIT) ? MAX_WAIT : d;
      for (int j = 1; j <= nb; j++) begin
         @(posedge clk);
         #1;
         bus.mem_ready_i = (j == d);
         bus.mem_rdata_i = (j == d) ? mrd : $urandom();
         if (drop_mid && j == 1) begin
            if (exp_aux) bus.aux_req_i = 1'b0;
            else         bus.core_req_i = 1'b0;
         end
         @(negedge clk);
         chk1("busy_mem_req", bus.mem_req_o, 1'b1);
         chk1("busy_mem_we", bus.mem_we_o, we);
         chk32("busy_mem_addr", bus.mem_addr_o, addr);
         chk32("busy_mem_wdata", bus.mem_wdata_o, wd);
         chk1("busy_no_ack", bus.core_ack_o | bus.aux_ack_o, 1'b0);
         chk1("busy_flag", bus.busy_o, 1'b1);
      end
      @(posedge clk);
      #1;
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
      chk1("resp_core_ack", bus.core_ack_o, !exp_aux);
      chk1("resp_aux_ack", bus.aux_ack_o, exp_aux);
      chk1("resp_err", bus.err_o, exp_err);
      chk1("resp_mem_req", bus.mem_req_o, 1'b0);
      if (exp_aux) begin
         chk32("resp_aux_rdata", bus.aux_rdata_o, exp_rd);
         chk32("resp_core_rdata_hold", bus.core_rdata_o, trk_core_rd);
         trk_aux_rd = exp_rd;
      end else begin
         chk32("resp_core_rdata", bus.core_rdata_o, exp_rd);
         chk32("resp_aux_rdata_hold", bus.aux_rdata_o, trk_aux_rd);
         trk_core_rd = exp_rd;
      end
      m_last_aux = exp_aux;
      if (drop_after) begin
         if (exp_aux) bus.aux_req_i = 1'b0;
         else         bus.core_req_i = 1'b0;
      end
      @(negedge clk);
      chk1("idle_busy", bus.busy_o, 1'b0);
      chk1("idle_no_ack", bus.core_ack_o | bus.aux_ack_o, 1'b0);
      chk1("idle_err", bus.err_o, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv[11];
      bit          cp, ap, ea, ee, dm, hold_exp;
      logic        we;
      logic [31:0] er, mrd;
      int          d;

      reset = 1'b1;
      bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_addr_i = '0; bus.core_wdata_i = '0;
      bus.aux_req_i  = 1'b0; bus.aux_we_i  = 1'b0; bus.aux_addr_i  = '0; bus.aux_wdata_i  = '0;
      bus.mem_rdata_i = '0;  bus.mem_ready_i = 1'b0;
      model_reset();

      // creq areq cwe awe caddr aaddr cwd awd d mrd drop_mid exp_aux exp_err exp_rd
      tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0, 32'h0,        3,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h40, 32'h0, 32'h12345678, 1,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h00000000};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0,  32'h0, 32'h0,        16, 32'h55555555, 1'b0, 1'b0, 1'b1, 32'h00000000};
      tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0,  32'h0, 32'h0,        2,  32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D};
      tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0,  32'h0, 32'h0,        15, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5};
      tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h28, 32'h0,  32'h77777777, 32'h0, 4,  32'h99999999, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};
      tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h44, 32'h0, 32'h0,        2,  32'h0BADCAFE, 1'b0, 1'b1, 1'b0, 32'h0BADCAFE};
      tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h48, 32'h0, 32'h0,        1,  32'h11111111, 1'b0, 1'b0, 1'b0, 32'h11111111};
      tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h48, 32'h0, 32'h0,        3,  32'h22222222, 1'b0, 1'b1, 1'b0, 32'h22222222};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h34, 32'h0,  32'h0, 32'h0,        1,  32'h33333333, 1'b0, 1'b0, 1'b0, 32'h33333333};
      tv[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h38, 32'h4C, 32'h0, 32'h0,        1,  32'h44444444, 1'b0, 1'b0, 1'b0, 32'h44444444};
`ifdef UCSBECE154A_ARB_RR_EN
      tv[10].exp_aux = 1'b1;
`endif

      @(negedge clk);
      chk1("rst_core_ack", bus.core_ack_o, 1'b0);
      chk1("rst_aux_ack", bus.aux_ack_o, 1'b0);
      chk1("rst_err", bus.err_o, 1'b0);
      chk1("rst_busy", bus.busy_o, 1'b0);
      chk1("rst_mem_req", bus.mem_req_o, 1'b0);
      chk1("rst_mem_we", bus.mem_we_o, 1'b0);
      chk32("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk32("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
      chk32("rst_core_rdata", bus.core_rdata_o, 32'h0);
      chk32("rst_aux_rdata", bus.aux_rdata_o, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         bus.core_req_i = tv[i].creq; bus.core_we_i = tv[i].cwe;
         bus.core_addr_i = tv[i].caddr; bus.core_wdata_i = tv[i].cwd;
         bus.aux_req_i = tv[i].areq; bus.aux_we_i = tv[i].awe;
         bus.aux_addr_i = tv[i].aaddr; bus.aux_wdata_i = tv[i].awd;
         do_round(tv[i].exp_aux, tv[i].exp_err, tv[i].exp_rd, tv[i].d, tv[i].mrd, tv[i].drop_mid, 1'b1);
      end
      bus.core_req_i = 1'b0;
      bus.aux_req_i  = 1'b0;
      @(negedge clk);
      chk1("table_end_idle", bus.busy_o, 1'b0);

      // Both requesters hold their requests continuously, memory always ready.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h100;
      bus.aux_req_i  = 1'b1; bus.aux_we_i  = 1'b0; bus.aux_addr_i  = 32'h200;
      for (int i = 0; i < 4; i++) begin
`ifdef UCSBECE154A_ARB_RR_EN
         hold_exp = (i % 2) == 1;
`else
         hold_exp = 1'b0;
`endif
         do_round(hold_exp, 1'b0, 32'h1000 + i, 1, 32'h1000 + i, 1'b0, 1'b0);
      end
      bus.core_req_i = 1'b0;
      bus.aux_req_i  = 1'b0;
      @(negedge clk);

      // Reset during the second BUSY cycle of a core read: transaction is dropped silently.
      bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h50;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk1("rstmid_mem_req", bus.mem_req_o, 1'b0);
      chk1("rstmid_busy", bus.busy_o, 1'b0);
      chk1("rstmid_ack", bus.core_ack_o | bus.aux_ack_o, 1'b0);
      bus.core_req_i  = 1'b0;
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = 32'h0000BEEF;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("rstmid_after_ack", bus.core_ack_o | bus.aux_ack_o, 1'b0);
         chk1("rstmid_after_busy", bus.busy_o, 1'b0);
         chk1("rstmid_after_mem_req", bus.mem_req_o, 1'b0);
      end
      chk32("rstmid_core_rdata", bus.core_rdata_o, 32'h0);
      bus.mem_ready_i = 1'b0;

      // Random traffic: each port keeps a request pending until it is served.
      cp = 1'b0;
      ap = 1'b0;
      for (int r = 0; r < 150; r++) begin
         if (!cp && $urandom_range(0, 2) != 0) begin
            cp = 1'b1;
            bus.core_req_i   = 1'b1;
            bus.core_we_i    = 1'($urandom_range(0, 1));
            bus.core_addr_i  = $urandom();
            bus.core_wdata_i = $urandom();
         end
         if (!ap && $urandom_range(0, 2) != 0) begin
            ap = 1'b1;
            bus.aux_req_i   = 1'b1;
            bus.aux_we_i    = 1'($urandom_range(0, 1));
            bus.aux_addr_i  = $urandom();
            bus.aux_wdata_i = $urandom();
         end
         if (!cp && !ap) begin
            @(negedge clk);
            chk1("rand_idle_busy", bus.busy_o, 1'b0);
            continue;
         end
`ifdef UCSBECE154A_ARB_RR_EN
         ea = (cp && ap) ? !m_last_aux : ap;
`else
         ea = (cp && ap) ? 1'b0 : ap;
`endif
         d   = $urandom_range(1, MAX_WAIT + 3);
         mrd = $urandom();
         we  = ea ? bus.aux_we_i : bus.core_we_i;
         ee  = d > MAX_WAIT;
         er  = ee ? 32'h0 : (we ? (ea ? trk_aux_rd : trk_core_rd) : mrd);
         dm  = ($urandom_range(0, 3) == 0);
         do_round(ea, ee, er, d, mrd, dm, 1'b1);
         if (ea) ap = 1'b0;
         else    cp = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ucsbece154a_mem_arbiter.md
Name: ucsbece154a_mem_arbiter

Overview:
Shares the single unified instruction/data memory port between two requesters: the multicycle core (fetch and load/store traffic) and an auxiliary port (program loader or debug).
Registers each granted transaction, holds it stable until the memory signals ready, then returns a one-cycle acknowledge with read data to the owner.
Adds a wait-state timeout so a hung memory cannot deadlock the core FSM.
Sits between the core's address mux (PC/ALU result) and the memory model.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width
MAX_WAIT  15  cycles a transaction may wait for mem_ready_i before abort; legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
core_req_i  in  1  core requests a transaction
core_we_i  in  1  core write enable
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core write data
core_ack_o  out  1  one-cycle completion pulse to core
core_rdata_o  out  DATA_W  read data to core
aux_req_i  in  1  aux requests a transaction
aux_we_i  in  1  aux write enable
aux_addr_i  in  ADDR_W  aux address
aux_wdata_i  in  DATA_W  aux write data
aux_ack_o  out  1  one-cycle completion pulse to aux
aux_rdata_o  out  DATA_W  read data to aux
err_o  out  1  qualifies an ack pulse as a timeout abort
busy_o  out  1  high while not IDLE
mem_req_o  out  1  memory transaction valid
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i
mem_ready_i  in  1  memory completes the current transaction this cycle

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). All outputs and state are registered.
- Reset values: every output is 0, state = IDLE, wait counter = 0, last_grant = AUX.
- States:
  - IDLE: sample requests. If any request is present, latch the winner's we/addr/wdata and owner, set mem_req_o=1 and go to BUSY; otherwise stay in IDLE.
  - BUSY: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held constant. Requester inputs are ignored.
  - BUSY with mem_ready_i=1: go to RESP; mem_req_o drops; the owner's ack is 1 during RESP. On a read, the owner's rdata register captures mem_rdata_i. On a write, the owner's rdata is unchanged.
  - BUSY timeout: if the counter reaches MAX_WAIT with no ready, go to RESP with err_o=1; the owner's rdata is set to 0.
  - RESP: lasts exactly one cycle. All requests are ignored. Next state is IDLE. err_o is cleared on leaving RESP.
- Wait counter: cleared on entering BUSY and incremented each BUSY cycle without ready. mem_ready_i in the same cycle the counter hits MAX_WAIT counts as success, not timeout.
- Latency: req seen in IDLE at cycle 0 -> mem_req_o at cycle 1 -> ready at cycle k (k>=1) -> ack at cycle k+1 -> IDLE at cycle k+2.
- Requester rule: hold req and payload until ack is sampled, then deassert. A req still high in IDLE after RESP is a new transaction. A req dropped while BUSY does not cancel the transaction; ack is still issued.
- Arbitration with both requests in IDLE: core wins (fixed priority), unless the optional feature is compiled in. last_grant updates on every grant.
- Only the owner's ack/rdata change; the other port's rdata holds its value.
- busy_o = (state != IDLE).
- Reset mid-transaction: mem_req_o drops immediately (async), no ack is issued, and the transaction is lost.
- Illegal state encodings recover to IDLE.

Optional Feature:
UCSBECE154A_ARB_RR_EN
- Defined: round-robin arbitration. With both requests in IDLE, the requester that did not get the last grant wins. After reset (last_grant=AUX) the core wins first. A lone requester always wins.
- Undefined: fixed priority, core over aux; last_grant is still tracked but not used.

Test Plan:
- Core read, addr 0x00000010, mem_ready_i at cycle 3 with rdata 0xDEADBEEF -> mem_req_o high cycles 1-3, core_ack_o pulse at cycle 4, core_rdata_o=0xDEADBEEF, err_o=0, aux ports unchanged.
- Aux write, addr 0x40, wdata 0x12345678, ready at cycle 1 -> mem_we_o=1 with addr/data stable, aux_ack_o at cycle 2, aux_rdata_o unchanged, busy_o low at cycle 3.
- Both requests held continuously, ready always 1 -> without macro, grants go core, core, core; with UCSBECE154A_ARB_RR_EN, grants go core, aux, core, aux.
- mem_ready_i never asserted, MAX_WAIT=15 -> mem_req_o high for exactly 15 cycles, then one-cycle ack with err_o=1 and rdata=0; next request proceeds normally.
- reset asserted mid-BUSY (cycle 2 of a core read) -> mem_req_o, busy_o and all acks are 0 in the same cycle; after release, state is IDLE and no ack is ever produced for the lost transaction.
- Core drops core_req_i while BUSY -> transaction completes, core_ack_o still pulses once; arbiter then stays in IDLE.
